// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the issue FSM state encoding
// used by the TX FIFO.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [0:0] {
        UTF_IDLE = 1'b0,
        UTF_WAIT = 1'b1
    } utf_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x UART_DATA_W register array for the TX FIFO.
// Ports:
//   clk_in       - system clock
//   we           - write enable, sampled on rising edge
//   waddr/wdata  - write address / byte
//   raddr/rdata  - asynchronous read address / byte
// The array is not reset; occupancy tracking lives in the parent.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                   clk_in,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UART_DATA_W-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [UART_DATA_W-1:0] rdata
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus issue controller feeding uart_tx. Producers push at clock
// rate; bytes are handed to uart_tx one at a time, the next strobe only
// after tx_finish of the previous byte.
// Ports:
//   clk_in, rst        - clock, asynchronous active-high reset
//   wr_en, wr_data     - push request and byte
//   full, empty, count - occupancy status (combinational from count)
//   overflow           - one-cycle pulse after a push dropped while full
//   tx_data_en         - one-cycle start strobe to uart_tx
//   tx_data_in         - byte to uart_tx, held until tx_finish
//   tx_finish          - uart_tx done pulse
//   busy               - a byte is in flight at uart_tx
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count,
    output logic                   overflow,
    output logic                   tx_data_en,
    output logic [UART_DATA_W-1:0] tx_data_in,
    input  logic                   tx_finish,
    output logic                   busy
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    utf_state_e             state_q, state_d;
    logic [AW-1:0]          wp_q, wp_d;
    logic [AW-1:0]          rp_q, rp_d;
    logic [AW:0]            count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   tx_data_en_q, tx_data_en_d;
    logic [UART_DATA_W-1:0] tx_data_in_q, tx_data_in_d;

    logic                   push;
    logic                   pop;
    logic [UART_DATA_W-1:0] rdata;

    // Flags come from the registered count, so a pop in the same cycle
    // never frees room for a push into a full FIFO.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign push  = wr_en && !full;
    assign pop   = (state_q == UTF_IDLE) && !empty;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_in (clk_in),
        .we     (push),
        .waddr  (wp_q),
        .wdata  (wr_data),
        .raddr  (rp_q),
        .rdata  (rdata)
    );

    // Pointers and occupancy
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        overflow_d = wr_en && full;
        if (push) wp_d = wp_q + PTR_ONE;
        if (pop)  rp_d = rp_q + PTR_ONE;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Issue FSM: one byte in flight at a time
    always_comb begin
        state_d      = state_q;
        tx_data_en_d = 1'b0;
        tx_data_in_d = tx_data_in_q;
        case (state_q)
            UTF_IDLE: begin
                if (pop) begin
                    tx_data_in_d = rdata;
                    tx_data_en_d = 1'b1;
                    state_d      = UTF_WAIT;
                end
            end
            UTF_WAIT: begin
                if (tx_finish) state_d = UTF_IDLE;
            end
            default: state_d = UTF_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q      <= UTF_IDLE;
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            tx_data_en_q <= 1'b0;
            tx_data_in_q <= '0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            tx_data_en_q <= tx_data_en_d;
            tx_data_in_q <= tx_data_in_d;
        end
    end

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign tx_data_en = tx_data_en_q;
    assign tx_data_in = tx_data_in_q;
    assign busy       = (state_q == UTF_WAIT);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small uart_tx responder model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          tx_data_en;
    logic [7:0]    tx_data_in;
    logic          tx_finish;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_data_en (tx_data_en),
        .tx_data_in (tx_data_in),
        .tx_finish  (tx_finish),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int         ovf_n;
        int         nxt_push;
        int         rcv;
        int         timer;
        int         en_seen;
        bit         inflight;
        bit         fin_req;
        bit         pushing;
        logic [AW:0] prev_cnt;

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_finish = 1'b0;
        #12;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_en", tx_data_en, 0);
        check("rst_data", tx_data_in, 8'h00);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick;

        // Single byte
        wr_en = 1'b1; wr_data = 8'hA5;
        tick;
        wr_en = 1'b0;
        check("one_count", count, 1);
        check("one_empty", empty, 0);
        check("one_en_early", tx_data_en, 0);
        tick;
        check("one_en", tx_data_en, 1);
        check("one_data", tx_data_in, 8'hA5);
        check("one_busy", busy, 1);
        check("one_empty_pop", empty, 1);
        tick;
        check("one_en_pulse", tx_data_en, 0);
        check("one_busy_hold", busy, 1);
        check("one_data_hold", tx_data_in, 8'hA5);
        tx_finish = 1'b1;
        tick;
        tx_finish = 1'b0;
        check("one_busy_done", busy, 0);
        tick;
        check("one_no_en", tx_data_en, 0);

        // Spurious finish in IDLE
        tx_finish = 1'b1;
        tick;
        tx_finish = 1'b0;
        check("spur_busy", busy, 0);
        check("spur_en", tx_data_en, 0);
        check("spur_count", count, 0);
        check("spur_empty", empty, 1);

        // Overflow: 18 pushes, tx_finish held low
        ovf_n = 0;
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick;
            if (overflow) ovf_n++;
            if (i == 1) begin
                check("ovf_first_en", tx_data_en, 1);
                check("ovf_first_data", tx_data_in, 8'h10);
            end
        end
        wr_en = 1'b0;
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
        check("ovf_pulses", ovf_n, 1);
        check("ovf_pulse_now", overflow, 1);
        tick;
        check("ovf_clear", overflow, 0);
        check("ovf_count_hold", count, 16);
        for (int j = 0; j < 16; j++) begin
            tx_finish = 1'b1;
            tick;
            tx_finish = 1'b0;
            check("drain_gap", tx_data_en, 0);
            tick;
            check("drain_en", tx_data_en, 1);
            check("drain_data", tx_data_in, 8'(8'h11 + j));
        end
        check("drain_empty", empty, 1);
        tx_finish = 1'b1;
        tick;
        tx_finish = 1'b0;
        check("drain_busy", busy, 0);

        // Stream 40 bytes while draining through a responder model
        nxt_push = 0; rcv = 0; timer = 0; inflight = 0; fin_req = 0;
        for (int cyc = 0; cyc < 2000 && !(rcv == 40 && !inflight); cyc++) begin
            wr_en     = (nxt_push < 40) && !full;
            wr_data   = 8'(nxt_push);
            pushing   = wr_en;
            prev_cnt  = count;
            tx_finish = fin_req;
            fin_req   = 0;
            tick;
            if (tx_finish) inflight = 0;
            if (pushing) nxt_push++;
            check("stream_cnt_max", 32'(count <= (AW+1)'(DEPTH)), 1);
            if (tx_data_en) begin
                check("stream_overlap", inflight, 0);
                check("stream_order", tx_data_in, 8'(rcv));
                if (pushing) check("stream_cnt_hold", count, prev_cnt);
                rcv++;
                inflight = 1;
                timer = 3;
            end else if (inflight && !tx_finish) begin
                timer--;
                if (timer == 0) fin_req = 1;
            end
        end
        wr_en = 1'b0; tx_finish = 1'b0;
        check("stream_rcv", rcv, 40);
        check("stream_pushed", nxt_push, 40);
        check("stream_empty", empty, 1);
        check("stream_busy", busy, 0);

        // Reset mid-operation: one in flight, 5 queued
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h60 + i);
            tick;
        end
        wr_en = 1'b0;
        check("mid_busy", busy, 1);
        check("mid_count", count, 5);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_full", full, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", tx_data_en, 0);
        check("mid_rst_data", tx_data_in, 8'h00);
        check("mid_rst_ovf", overflow, 0);
        rst = 1'b0;
        en_seen = 0;
        repeat (5) begin
            tick;
            if (tx_data_en) en_seen++;
        end
        check("post_rst_no_en", en_seen, 0);
        check("post_rst_count", count, 0);
        wr_en = 1'b1; wr_data = 8'h77;
        tick;
        wr_en = 1'b0;
        tick;
        check("post_rst_en", tx_data_en, 1);
        check("post_rst_data", tx_data_in, 8'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO and issue controller between a byte producer (CPU/logic side) and `uart_tx`. Producers push bytes at clock rate; the block hands them to `uart_tx` one at a time with its `tx_data_en` / `tx_data_in` / `tx_finish` handshake. No byte is issued before the previous one has finished. This decouples bursty producers from the slow baud-paced serialiser.

## Interface

Parameters:
- `DEPTH`, 16: FIFO capacity in bytes; power of two, ≥2.
- `AW`, 4: address width, equals log2(`DEPTH`).

Ports:
- `clk_in` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: push request, sampled on rising edge.
- `wr_data` in 8: byte to push.
- `full` out 1: FIFO holds `DEPTH` bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `count` out AW+1: current occupancy, 0..`DEPTH`.
- `overflow` out 1: one-cycle pulse when a push is dropped because the FIFO is full.
- `tx_data_en` out 1: one-cycle strobe to `uart_tx`: start sending `tx_data_in`.
- `tx_data_in` out 8: byte for `uart_tx`; held stable from strobe until `tx_finish`.
- `tx_finish` in 1: one-cycle pulse from `uart_tx`: current byte (incl. stop bit) done.
- `busy` out 1: a byte is in flight at `uart_tx`.

## Operation

- Storage: circular buffer, `DEPTH`×8, write pointer `wp` and read pointer `rp` of width AW (natural wrap), occupancy counter `count` of width AW+1.
- Push: accepted when `wr_en && !full`. `wr_data` is written at `wp`, and `wp` increments.
- Push while full: data dropped, pointers and count unchanged, `overflow`=1 next cycle for exactly one cycle.
- Pop: performed internally by the issue FSM only.
- Simultaneous accepted push and pop: `count` is unchanged and both pointers advance. When full, a push in the same cycle as a pop is still rejected, because `full` is evaluated before the pop.
- Issue FSM, states:
  - IDLE: `busy`=0. If `!empty`: latch `mem[rp]` into `tx_data_in`, increment `rp`, decrement `count`, assert `tx_data_en` for one cycle, go to WAIT.
  - WAIT: `busy`=1, `tx_data_en`=0, `tx_data_in` held. On `tx_finish`=1 go to IDLE.
- `tx_finish` in IDLE is ignored.
- Flags are combinational from `count`: `full` = (`count`==`DEPTH`), `empty` = (`count`==0).
- Reset, asynchronous, takes effect immediately, including mid-frame: `wp`=`rp`=0, `count`=0, state IDLE, `tx_data_en`=0, `tx_data_in`=8'h00, `overflow`=0, `busy`=0, `empty`=1, `full`=0. Memory contents are not cleared. The in-flight `uart_tx` frame is not the block's concern; `uart_tx` shares `rst`.

## Timing

- Push at edge N: `count`, `empty` and `full` reflect it after edge N.
- Empty FIFO, push at edge N: `tx_data_en` is high during the cycle after edge N+1, so first-byte latency is 2 cycles.
- `tx_finish` high at edge M: state is IDLE after M. If more bytes are waiting, the next `tx_data_en` is registered at edge M+1. Gap between `tx_finish` and the next strobe is therefore 1 cycle.
- `tx_data_en` is registered, never high for two consecutive cycles, and never high while `busy` was already 1.
- `overflow` is registered: it pulses the cycle after the rejected push edge.
- Pointer wrap: `wp` and `rp` roll over from `DEPTH`-1 to 0 with no special case. `count` distinguishes full from empty.

## Structure

- Shared package `uart_pkg`: `UART_DATA_W`=8; FSM state encoding `UTF_IDLE`, `UTF_WAIT`.
- One sub-module, `uart_fifo_mem`: DEPTH×8 register array with synchronous write port (`we`, `waddr`, `wdata`) and asynchronous read (`raddr` → `rdata`). No reset on the array.
- Top `uart_tx_fifo` contains the pointers, count, flags and issue FSM. It is instantiated beside `uart_tx`/`baud_gen`, with `tx_data_en`/`tx_data_in`/`tx_finish` wired port-to-port.

## Test plan

- Single byte: reset, push 8'hA5 at edge N → `tx_data_en` 1 cycle after edge N+1 with `tx_data_in`=8'hA5, `busy`=1 until the cycle after `tx_finish`, `empty`=1 after the pop.
- Burst ordering: push 8'h01..8'h05 back-to-back with `uart_tx` + `baud_gen` in loop → `uart_rx` receives 01,02,03,04,05 in order; exactly one `tx_data_en` per `tx_finish`.
- Overflow: DEPTH=16, hold `tx_finish` low, push 18 bytes → first strobe pops 1 byte, `count` saturates at 16, `full`=1, exactly one `overflow` pulse for the single dropped byte; remaining bytes drain correctly afterwards.
- Wrap and simultaneous push/pop: stream 40 bytes (values 0..39) while draining → pointers wrap twice, `count` never exceeds `DEPTH`, output order is 0..39, and `count` stays constant in cycles where a push and a pop coincide.
- Reset mid-operation: assert `rst` while `busy`=1 with 5 bytes queued → all outputs reach reset values asynchronously; after release, no `tx_data_en` appears until a new push.
- Spurious finish: pulse `tx_finish` in IDLE with FIFO empty → no state change, no strobe, `count` stays 0.
